// File: rtl/wb_commit_queue_pkg.sv
// wb_commit_queue_pkg
//   Shared definitions for the write-back commit queue slice.
//   - Default field widths for result data, register index and pc.
//   - Entry record layout {gr_we, dest, result, pc} at default widths.
//   - Width of the flattened memory-stage to write-back bus.
package wb_commit_queue_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_PC_W   = 32;

  // One queued retirement, as carried on the ms-to-ws bus
  typedef struct packed {
    logic                  gr_we;
    logic [DEF_ADDR_W-1:0] dest;
    logic [DEF_DATA_W-1:0] result;
    logic [DEF_PC_W-1:0]   pc;
  } wbEntry_t;

  localparam int MS_TO_WS_BUS_W = $bits(wbEntry_t);

endpackage

// File: rtl/wb_commit_queue_fwd_lookup.sv
// wb_fwd_lookup
//   Youngest-match search over the commit queue for one decode read port.
//   Ports:
//     i_valid/i_grWe/i_dest/i_result : per-slot entry state
//     i_head, i_count                : oldest slot and number of pending entries
//     i_raddr                        : decode register index being looked up
//     o_hit, o_fwd                   : match flag and matched result (0 on miss)
module wb_fwd_lookup #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2,
  parameter int PTR_W  = 1,
  parameter int CNT_W  = 2
) (
  input  logic              i_valid  [DEPTH],
  input  logic              i_grWe   [DEPTH],
  input  logic [ADDR_W-1:0] i_dest   [DEPTH],
  input  logic [DATA_W-1:0] i_result [DEPTH],
  input  logic [PTR_W-1:0]  i_head,
  input  logic [CNT_W-1:0]  i_count,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic              o_hit,
  output logic [DATA_W-1:0] o_fwd
);

  // Walk slots from oldest to youngest; a later match overwrites an earlier
  // one, so the youngest matching entry is what remains at the end.
  always_comb begin
    logic [PTR_W-1:0] w_idx;
    o_hit = 1'b0;
    o_fwd = '0;
    w_idx = i_head;
    for (int i = 0; i < DEPTH; i++) begin
      if ((i < int'(i_count)) && i_valid[w_idx] && i_grWe[w_idx] &&
          (i_dest[w_idx] == i_raddr) && (i_raddr != '0)) begin
        o_hit = 1'b1;
        o_fwd = i_result[w_idx];
      end
      w_idx = (w_idx == PTR_W'(DEPTH - 1)) ? '0 : w_idx + PTR_W'(1);
    end
  end

endmodule

// File: rtl/wb_commit_queue.sv
// wb_commit_queue
//   In-order DEPTH-entry write-back queue between the memory stage and the
//   register-file write port, with two youngest-match forwarding lookups.
//   Ports:
//     clk, reset (async, active high)
//     ms_to_ws_valid / ws_allowin       : memory-stage handshake
//     in_gr_we, in_dest, in_result, in_pc : incoming entry
//     rf_ready, rf_we, rf_waddr, rf_wdata : RF write port (head entry)
//     ws_empty                            : queue holds no entry
//     ds_raddr1/2 -> ws_hit1/2, ws_fwd1/2 : decode hazard/forward lookups
//   Optional: define WB_TRACE_EN to add debug_wb_pc, debug_wb_rf_wen,
//   debug_wb_rf_wnum and debug_wb_rf_wdata retirement trace ports.
module wb_commit_queue
  import wb_commit_queue_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int PC_W   = DEF_PC_W,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ms_to_ws_valid,
  output logic              ws_allowin,
  input  logic              in_gr_we,
  input  logic [ADDR_W-1:0] in_dest,
  input  logic [DATA_W-1:0] in_result,
  input  logic [PC_W-1:0]   in_pc,
  input  logic              rf_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              ws_empty,
  input  logic [ADDR_W-1:0] ds_raddr1,
  input  logic [ADDR_W-1:0] ds_raddr2,
  output logic              ws_hit1,
  output logic              ws_hit2,
  output logic [DATA_W-1:0] ws_fwd1,
  output logic [DATA_W-1:0] ws_fwd2
`ifdef WB_TRACE_EN
  ,
  output logic [PC_W-1:0]   debug_wb_pc,
  output logic [3:0]        debug_wb_rf_wen,
  output logic [ADDR_W-1:0] debug_wb_rf_wnum,
  output logic [DATA_W-1:0] debug_wb_rf_wdata
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;
  logic              r_valid  [DEPTH];
  logic              r_grWe   [DEPTH];
  logic [ADDR_W-1:0] r_dest   [DEPTH];
  logic [DATA_W-1:0] r_result [DEPTH];

  logic              w_push;
  logic              w_pop;
  logic              w_nonEmpty;
  logic [PTR_W-1:0]  w_headNext;
  logic [PTR_W-1:0]  w_tailNext;

  assign w_nonEmpty = (r_count != '0);
  assign w_pop      = w_nonEmpty && rf_ready;
  // Full queue still accepts when the head retires in the same cycle
  assign ws_allowin = (r_count < CNT_W'(DEPTH)) || w_pop;
  assign w_push     = ms_to_ws_valid && ws_allowin;

  assign w_headNext = (r_head == PTR_W'(DEPTH - 1)) ? '0 : r_head + PTR_W'(1);
  assign w_tailNext = (r_tail == PTR_W'(DEPTH - 1)) ? '0 : r_tail + PTR_W'(1);

  assign ws_empty = !w_nonEmpty;
  assign rf_we    = w_pop && r_grWe[r_head] && (r_dest[r_head] != '0);
  assign rf_waddr = r_dest[r_head];
  assign rf_wdata = r_result[r_head];

  // Pointer/count/valid state. When full with push and pop together the
  // head and tail slot coincide, so the push update is ordered last to win.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_valid[i] <= 1'b0;
      end
    end else begin
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= w_headNext;
      end
      if (w_push) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= w_tailNext;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Payloads carry no reset; they are only meaningful while valid
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_grWe[r_tail]   <= in_gr_we;
      r_dest[r_tail]   <= in_dest;
      r_result[r_tail] <= in_result;
    end
  end

  wb_fwd_lookup #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W),
    .CNT_W  (CNT_W)
  ) u_lookup1 (
    .i_valid  (r_valid),
    .i_grWe   (r_grWe),
    .i_dest   (r_dest),
    .i_result (r_result),
    .i_head   (r_head),
    .i_count  (r_count),
    .i_raddr  (ds_raddr1),
    .o_hit    (ws_hit1),
    .o_fwd    (ws_fwd1)
  );

  wb_fwd_lookup #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W),
    .CNT_W  (CNT_W)
  ) u_lookup2 (
    .i_valid  (r_valid),
    .i_grWe   (r_grWe),
    .i_dest   (r_dest),
    .i_result (r_result),
    .i_head   (r_head),
    .i_count  (r_count),
    .i_raddr  (ds_raddr2),
    .o_hit    (ws_hit2),
    .o_fwd    (ws_fwd2)
  );

`ifdef WB_TRACE_EN
  logic [PC_W-1:0] r_pc [DEPTH];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc[r_tail] <= in_pc;
    end
  end

  // Trace shows the head entry; everything reads 0 while the queue is empty
  assign debug_wb_pc       = w_nonEmpty ? r_pc[r_head]     : '0;
  assign debug_wb_rf_wen   = {4{rf_we}};
  assign debug_wb_rf_wnum  = w_nonEmpty ? r_dest[r_head]   : '0;
  assign debug_wb_rf_wdata = w_nonEmpty ? r_result[r_head] : '0;
`else
  // The pc only feeds the trace ports, which are absent in this build
  logic w_unusedPc;
  assign w_unusedPc = ^in_pc;
`endif

endmodule

// File: tb/tb_wb_commit_queue.sv
// tb_wb_commit_queue
//   Self-checking bench: instance A (DEPTH=2) runs directed scenarios,
//   instance B (DEPTH=3) runs a randomised rf_ready drain of 10 entries.
//   A scoreboard queue per instance models the expected queue contents.
module tb_wb_commit_queue;

  typedef struct {
    logic        we;
    logic [4:0]  dest;
    logic [31:0] res;
    logic [31:0] pc;
  } ent_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Instance A stimulus/observation
  logic        validA, grWeA, rfReadyA;
  logic [4:0]  destA, raddr1A, raddr2A;
  logic [31:0] resultA, pcA;
  logic        allowA, rfWeA, emptyA, hit1A, hit2A;
  logic [4:0]  waddrA;
  logic [31:0] wdataA, fwd1A, fwd2A;

  // Instance B stimulus/observation
  logic        validB, grWeB, rfReadyB;
  logic [4:0]  destB;
  logic [31:0] resultB, pcB;
  logic        allowB, rfWeB, emptyB, hit1B, hit2B;
  logic [4:0]  waddrB;
  logic [31:0] wdataB, fwd1B, fwd2B;

`ifdef WB_TRACE_EN
  logic [31:0] dbgPcA, dbgWdataA, dbgPcB, dbgWdataB;
  logic [3:0]  dbgWenA, dbgWenB;
  logic [4:0]  dbgWnumA, dbgWnumB;
`endif

  wb_commit_queue #(.DATA_W(32), .ADDR_W(5), .PC_W(32), .DEPTH(2)) dutA (
    .clk(clk), .reset(reset),
    .ms_to_ws_valid(validA), .ws_allowin(allowA),
    .in_gr_we(grWeA), .in_dest(destA), .in_result(resultA), .in_pc(pcA),
    .rf_ready(rfReadyA), .rf_we(rfWeA), .rf_waddr(waddrA), .rf_wdata(wdataA),
    .ws_empty(emptyA), .ds_raddr1(raddr1A), .ds_raddr2(raddr2A),
    .ws_hit1(hit1A), .ws_hit2(hit2A), .ws_fwd1(fwd1A), .ws_fwd2(fwd2A)
`ifdef WB_TRACE_EN
    , .debug_wb_pc(dbgPcA), .debug_wb_rf_wen(dbgWenA),
    .debug_wb_rf_wnum(dbgWnumA), .debug_wb_rf_wdata(dbgWdataA)
`endif
  );

  wb_commit_queue #(.DATA_W(32), .ADDR_W(5), .PC_W(32), .DEPTH(3)) dutB (
    .clk(clk), .reset(reset),
    .ms_to_ws_valid(validB), .ws_allowin(allowB),
    .in_gr_we(grWeB), .in_dest(destB), .in_result(resultB), .in_pc(pcB),
    .rf_ready(rfReadyB), .rf_we(rfWeB), .rf_waddr(waddrB), .rf_wdata(wdataB),
    .ws_empty(emptyB), .ds_raddr1(5'd0), .ds_raddr2(5'd0),
    .ws_hit1(hit1B), .ws_hit2(hit2B), .ws_fwd1(fwd1B), .ws_fwd2(fwd2B)
`ifdef WB_TRACE_EN
    , .debug_wb_pc(dbgPcB), .debug_wb_rf_wen(dbgWenB),
    .debug_wb_rf_wnum(dbgWnumB), .debug_wb_rf_wdata(dbgWdataB)
`endif
  );

  int nChecks = 0;
  int nPass   = 0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    if (obs === exp) nPass++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Youngest-wins model lookup: scan oldest to youngest, keep the last match
  function automatic logic [32:0] modelLookup(input ent_t q[$], input logic [4:0] a);
    logic [32:0] r;
    r = '0;
    if (a != 5'd0) begin
      foreach (q[i]) if (q[i].we && q[i].dest == a) r = {1'b1, q[i].res};
    end
    return r;
  endfunction

  ent_t mqA[$];
  ent_t mqB[$];

  // Scoreboard A: check outputs against the model mid-cycle, then apply
  // the pop/push that the coming clock edge will perform.
  always @(negedge clk) begin : monA
    int n;
    logic expPop, expAllow, expWe;
    logic [32:0] lk1, lk2;
    ent_t e;
    if (reset) begin
      checkOutput("A_rst_empty", 64'(emptyA), 64'd1);
      checkOutput("A_rst_rfwe", 64'(rfWeA), 64'd0);
      checkOutput("A_rst_allow", 64'(allowA), 64'd1);
      checkOutput("A_rst_hits", 64'({hit1A, hit2A}), 64'd0);
      mqA.delete();
    end else begin
      n = mqA.size();
      expPop = (n != 0) && rfReadyA;
      expAllow = (n < 2) || expPop;
      checkOutput("A_allowin", 64'(allowA), 64'(expAllow));
      checkOutput("A_empty", 64'(emptyA), 64'(n == 0));
      expWe = expPop && mqA[0].we && (mqA[0].dest != 5'd0);
      checkOutput("A_rf_we", 64'(rfWeA), 64'(expWe));
      if (expWe) begin
        checkOutput("A_rf_waddr", 64'(waddrA), 64'(mqA[0].dest));
        checkOutput("A_rf_wdata", 64'(wdataA), 64'(mqA[0].res));
      end
      lk1 = modelLookup(mqA, raddr1A);
      lk2 = modelLookup(mqA, raddr2A);
      checkOutput("A_lookup1", 64'({hit1A, fwd1A}), 64'(lk1));
      checkOutput("A_lookup2", 64'({hit2A, fwd2A}), 64'(lk2));
`ifdef WB_TRACE_EN
      checkOutput("A_dbg_pc", 64'(dbgPcA), (n != 0) ? 64'(mqA[0].pc) : 64'd0);
      checkOutput("A_dbg_wen", 64'(dbgWenA), 64'({4{expWe}}));
`endif
      if (expPop) void'(mqA.pop_front());
      if (validA && expAllow) begin
        e.we = grWeA; e.dest = destA; e.res = resultA; e.pc = pcA;
        mqA.push_back(e);
      end
    end
  end

  ent_t tblB [10];
  int   idxB = 0;

  // Scoreboard B: in-order retirement of the randomised drain
  always @(negedge clk) begin : monB
    int n;
    logic expPop, expAllow, expWe;
    if (reset) begin
      mqB.delete();
    end else begin
      n = mqB.size();
      expPop = (n != 0) && rfReadyB;
      expAllow = (n < 3) || expPop;
      checkOutput("B_allowin", 64'(allowB), 64'(expAllow));
      checkOutput("B_empty", 64'(emptyB), 64'(n == 0));
      expWe = expPop && mqB[0].we && (mqB[0].dest != 5'd0);
      checkOutput("B_rf_we", 64'(rfWeB), 64'(expWe));
      if (expWe) begin
        checkOutput("B_rf_waddr", 64'(waddrB), 64'(mqB[0].dest));
        checkOutput("B_rf_wdata", 64'(wdataB), 64'(mqB[0].res));
      end
      if (expPop) void'(mqB.pop_front());
      if (validB && expAllow) begin
        mqB.push_back(tblB[idxB]);
        idxB++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic we, input logic [4:0] d,
                               input logic [31:0] r, input logic [31:0] p, input logic rdy);
    validA = v; grWeA = we; destA = d; resultA = r; pcA = p; rfReadyA = rdy;
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0);
    raddr1A = 5'd3; raddr2A = 5'd0;
    validB = 0; grWeB = 0; destB = 0; resultB = 0; pcB = 0; rfReadyB = 0;
    step(); step();
    checkOutput("rst_empty", 64'(emptyA), 64'd1);
    checkOutput("rst_allow", 64'(allowA), 64'd1);
    reset = 1'b0;

    // Single entry through a ready RF port: written one cycle later
    applyStimulus(1, 1, 5'd3, 32'hAA, 32'h1c000000, 1); step();
    applyStimulus(0, 0, 0, 0, 0, 1); step(); step();

    // Fill while stalled, third entry held off, then push+pop together
    applyStimulus(1, 1, 5'd4, 32'h101, 32'h1c000010, 0); step();
    applyStimulus(1, 1, 5'd6, 32'h102, 32'h1c000014, 0); step();
    applyStimulus(1, 1, 5'd7, 32'h103, 32'h1c000018, 0); step();
    applyStimulus(1, 1, 5'd7, 32'h103, 32'h1c000018, 1); step();
    applyStimulus(0, 0, 0, 0, 0, 1); step(); step(); step();

    // Two pending writes to r5: the younger result must be forwarded
    raddr1A = 5'd5; raddr2A = 5'd0;
    applyStimulus(1, 1, 5'd5, 32'h11, 32'h1c000020, 0); step();
    applyStimulus(1, 1, 5'd5, 32'h22, 32'h1c000024, 0); step();
    applyStimulus(0, 0, 0, 0, 0, 0); step();
    raddr2A = 5'd5;
    applyStimulus(0, 0, 0, 0, 0, 1); step(); step(); step();

    // Non-writing entries retire in order without an RF strobe
    raddr1A = 5'd0; raddr2A = 5'd7;
    applyStimulus(1, 1, 5'd0, 32'h33, 32'h1c000030, 0); step();
    applyStimulus(1, 0, 5'd7, 32'h44, 32'h1c000034, 0); step();
    applyStimulus(0, 0, 0, 0, 0, 1); step(); step(); step();

    // Asynchronous reset while two entries are draining
    raddr1A = 5'd9; raddr2A = 5'd10;
    applyStimulus(1, 1, 5'd9, 32'h55, 32'h1c000040, 0); step();
    applyStimulus(1, 1, 5'd10, 32'h66, 32'h1c000044, 0); step();
    applyStimulus(0, 0, 0, 0, 0, 1);
    #1;
    checkOutput("pre_rst_hit1", 64'({hit1A, fwd1A}), {31'd0, 1'b1, 32'h55});
    reset = 1'b1;
    #1;
    checkOutput("midrst_empty", 64'(emptyA), 64'd1);
    checkOutput("midrst_rfwe", 64'(rfWeA), 64'd0);
    checkOutput("midrst_hits", 64'({hit1A, hit2A}), 64'd0);
    step();
    reset = 1'b0;
    applyStimulus(1, 1, 5'd9, 32'h77, 32'h1c000050, 0); step();
    applyStimulus(0, 0, 0, 0, 0, 1); step(); step();

    // Randomised stall pattern on a 3-deep queue; pointers wrap several times
    for (int i = 0; i < 10; i++) begin
      tblB[i].we   = (i != 4);
      tblB[i].dest = 5'(i % 3 + 1);
      tblB[i].res  = $urandom;
      tblB[i].pc   = 32'h1c001000 + 32'(i * 4);
    end
    for (int cyc = 0; cyc < 400 && (idxB < 10 || mqB.size() != 0); cyc++) begin
      validB = (idxB < 10);
      if (idxB < 10) begin
        grWeB = tblB[idxB].we; destB = tblB[idxB].dest;
        resultB = tblB[idxB].res; pcB = tblB[idxB].pc;
      end
      rfReadyB = 1'($urandom_range(0, 1));
      step();
    end
    validB = 0;
    checkOutput("B_all_pushed", 64'(idxB), 64'd10);
    checkOutput("B_drained", 64'(mqB.size()), 64'd0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/wb_commit_queue.md
Name: wb_commit_queue

Overview:
- Parametrised successor to the single-entry write-back stage.
- Takes retiring instructions from the memory stage through a valid/allowin handshake and buffers them in a DEPTH-entry in-order queue.
- Drains the queue to the register-file write port, which may stall through rf_ready.
- Provides two youngest-match hazard/forwarding lookups for decode over every pending entry.

Parameters:
- DATA_W, 32, result/write-data width
- ADDR_W, 5, register index width
- PC_W, 32, pc width
- DEPTH, 2, queue entries; must be >= 1; not required to be a power of two

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- ms_to_ws_valid  in  1  memory stage offers an entry
- ws_allowin  out  1  queue accepts the entry this cycle
- in_gr_we  in  1  entry writes a GPR
- in_dest  in  ADDR_W  destination register
- in_result  in  DATA_W  final result
- in_pc  in  PC_W  instruction pc
- rf_ready  in  1  RF write port accepts the head entry this cycle
- rf_we  out  1  RF write strobe
- rf_waddr  out  ADDR_W  RF write address
- rf_wdata  out  DATA_W  RF write data
- ws_empty  out  1  queue holds no entry
- ds_raddr1  in  ADDR_W  decode lookup 1 address
- ds_raddr2  in  ADDR_W  decode lookup 2 address
- ws_hit1  out  1  lookup 1 matches a pending entry
- ws_hit2  out  1  lookup 2 matches a pending entry
- ws_fwd1  out  DATA_W  lookup 1 data
- ws_fwd2  out  DATA_W  lookup 2 data

Behaviour:
- Reset (asynchronous, any cycle, including mid-drain):
  - count=0, head=tail=0, all entry valid bits cleared, entry payloads left undefined.
  - Outputs after reset: ws_empty=1, rf_we=0, ws_allowin=1, ws_hit1=ws_hit2=0.
- push = ms_to_ws_valid && ws_allowin. The entry is written at the tail; tail advances and wraps from DEPTH-1 to 0.
- pop = (count!=0) && rf_ready. The head entry retires and head advances with the same wrap rule.
- ws_allowin = (count<DEPTH) || pop. This is a combinational path from rf_ready, so a push and a pop in the same cycle are legal when the queue is full.
- Count update: push only -> count+1; pop only -> count-1; both -> count unchanged. Count never exceeds DEPTH and never underflows.
- Latency:
  - An entry pushed in cycle N is at the head no earlier than N+1.
  - An empty queue gives no bypass from input to RF.
  - Minimum input-to-RF-write latency is 1 cycle.
- RF outputs are combinational from the head entry:
  - rf_we = pop && head.gr_we && (head.dest!=0).
  - rf_waddr = head.dest; rf_wdata = head.result.
  - Entries with gr_we=0 or dest=0 still occupy a slot and retire in order without writing.
- While rf_ready=0, the head holds and no output changes except through new pushes.
- Lookup k (k=1,2), combinational:
  - Considers valid entries with gr_we=1, dest==ds_raddrk and ds_raddrk!=0.
  - The youngest such entry (closest to tail) wins.
  - On a match: ws_hitk=1 and ws_fwdk=that entry's result. Otherwise ws_hitk=0 and ws_fwdk=0.
  - The head entry being popped this cycle is still visible to the lookup.
- Entry payloads are captured only on push. Valid bits are set on push and cleared on pop.

Optional Feature:
- Macro WB_TRACE_EN.
- Defined:
  - Adds ports debug_wb_pc (PC_W), debug_wb_rf_wen (4), debug_wb_rf_wnum (ADDR_W), debug_wb_rf_wdata (DATA_W).
  - debug_wb_rf_wen = {4{rf_we}}. pc, wnum and wdata come from the head entry.
  - A retiring entry with no write shows wen=0 with its pc.
  - All four debug outputs are 0 when empty or in reset.
- Undefined: the debug ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Shared package:
  - Field-width constants: DATA_W, ADDR_W, PC_W defaults.
  - Entry typedef {gr_we, dest, result, pc}.
  - Flattened-bus width constant for the ms-to-ws bus.
- One sub-module, wb_fwd_lookup:
  - Parametrised youngest-match search over the entry array plus head/count.
  - Instantiated twice, once per lookup port.

Test Plan:
- Reset with DEPTH=2: push {we=1,dest=3,res=0xAA,pc=0x1c000000} with rf_ready=1 -> next cycle rf_we=1, waddr=3, wdata=0xAA; the following cycle ws_empty=1.
- rf_ready=0, push 3 entries back-to-back -> first two accepted, ws_allowin=0 on the third. Raise rf_ready -> third accepted in the same cycle as the first pop; retire order is preserved.
- Queue holds dest=5/res=0x11 (older) and dest=5/res=0x22 (younger); ds_raddr1=5 -> ws_hit1=1, ws_fwd1=0x22. ds_raddr2=0 -> ws_hit2=0.
- Entry with dest=0, we=1 and entry with we=0 -> both retire with rf_we=0. With WB_TRACE_EN, debug_wb_pc steps through both pcs with wen=0.
- Assert reset mid-drain with 2 entries queued -> immediately ws_empty=1, rf_we=0, hits=0; the next push is accepted normally.
- DEPTH=3 with 10 pushes and random rf_ready -> pointers wrap correctly and the RF write sequence equals the push sequence.
